mem_wb_pipe: RTL and testbench
==============================

// Module: mem_wb_pipe
// PURPOSE
//  Parametrised MEM->WB pipeline register, generalised to LANES parallel writeback lanes.
//  Adds valid/ready handshake with a 2-entry skid buffer, synchronous flush and x0 write suppression.
//  Sits between the memory stage and the register-file write port.
//  Output payload is registered; no combinational path from in_* to out_*.
// PARAMETERS
//  LANES     1            writeback lanes carried per beat
//  ADDR_W    5            register address width
//  DATA_W    32           writeback data width
//  TYPE_W    7            instruction-type (opcode) field width
//  NOP_TYPE  7'b0010011   ins_type value emitted at reset/flush (ALOPI)
// PORTS
//  clk_in        in   1               clock, rising edge
//  rst_n_in      in   1               reset, asynchronous, active-low
//  rdy_in        in   1               global enable; 0 freezes all state
//  flush_in      in   1               discard all held beats
//  in_valid      in   1               upstream beat valid
//  in_ready      out  1               block can accept a beat
//  in_we         in   LANES           per-lane write enable
//  in_rd_addr    in   LANES*ADDR_W    per-lane destination, lane i at [i*ADDR_W +: ADDR_W]
//  in_rd_val     in   LANES*DATA_W    per-lane writeback value
//  in_ins_type   in   LANES*TYPE_W    per-lane instruction type
//  out_valid     out  1               head beat valid
//  out_ready     in   1               writeback consumes head beat
//  out_we        out  LANES           per-lane write enable, x0-suppressed
//  out_rd_addr   out  LANES*ADDR_W    head beat destinations
//  out_rd_val    out  LANES*DATA_W    head beat values
//  out_ins_type  out  LANES*TYPE_W    head beat types
//  occupancy     out  2               held beats: 0, 1 or 2
// BEHAVIOUR
//  Reset (rst_n_in=0, async):
//   - both entries invalid; out_valid=0, out_we=0, out_rd_addr=0, out_rd_val=0, out_ins_type=NOP_TYPE per lane.
//   - occupancy=0.
//  Storage: head entry (drives out_*) and skid entry. State is the occupancy:
//   - EMPTY (0), ONE (1, head valid), TWO (2, head and skid valid).
//  Handshake terms:
//   - in_ready = rdy_in & ~skid_valid (registered state; no dependency on out_ready).
//   - acc = in_valid & in_ready; pop = out_valid & out_ready & rdy_in.
//   - out_valid = head_valid, independent of rdy_in.
//  Transitions on rising clk_in, rdy_in=1, flush_in=0:
//   - EMPTY: acc -> head<=in, ONE.
//   - ONE:   acc&pop -> head<=in, stay ONE; acc&~pop -> skid<=in, TWO; ~acc&pop -> EMPTY.
//   - TWO:   pop -> head<=skid, ONE; no accept is possible (in_ready=0).
//  Latency: accepted beat reaches out_valid 1 cycle later when EMPTY, or when ONE with simultaneous pop.
//  Throughput: 1 beat/cycle sustained; ordering is strict FIFO.
//  rdy_in=0: every register holds and no transfer occurs. out_* stay stable.
//  flush_in=1 (takes priority over rdy_in and over acc/pop):
//   - next state is EMPTY; that cycle's input is dropped.
//   - out_* payload returns to reset values.
//  Write suppression: out_we[i] = stored we[i] & (stored rd_addr[i] != 0).
//   - payload is otherwise unchanged.
//  Invalid entries: out_we=0 whenever out_valid=0; invalid payload is don't-care except directly after reset or flush.
//  Reset mid-operation discards all beats asynchronously; the first accept after release behaves as from EMPTY.
// STRUCTURE
//  Shared package/include: NOP_TYPE (ALOPI) and ZeroWord constants; lane-slice helper macros.
//  One sub-module: mem_wb_lane_reg.
//   - a single-lane {we, addr, val, type} register with load, hold and clear.
//   - instanced per lane for head and skid.
//   - the top level holds occupancy control and x0 suppression.
// TESTING
//  Reset: assert rst_n_in mid-cycle with no clock edge -> out_valid=0, out_ins_type=7'h13, out_we=0, occupancy=0 at once.
//  Single beat, LANES=2:
//   - stimulus: in {we=2'b11, addr={5'd3,5'd0}, val={32'hDEAD_BEEF,32'h1}}, out_ready=1.
//   - next cycle: out_valid=1, out_we=2'b10, out_rd_val matches the input.
//  Backpressure:
//   - stimulus: out_ready=0, push beats A, B, C on consecutive cycles.
//   - required: A, B held; occupancy=2; in_ready=0 on the third cycle; C not accepted.
//   - then out_ready=1: A, B emitted in order.
//  Stall: rdy_in=0 for 3 cycles with in_valid=1, out_ready=1 -> no accept or pop; out_* and occupancy constant.
//  Flush: occupancy=2, then flush_in=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ins_type=NOP_TYPE.
//  Streaming: 100 random beats with random out_ready/rdy_in -> scoreboard sees exact in-order delivery, no loss or duplication.

Source files
------------

// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants and state encoding for the MEM->WB pipeline register.
// Occupancy doubles as the FSM state so it can be driven straight out.
package mem_wb_pipe_pkg;

   localparam logic [6:0]  ALOPI     = 7'b0010011;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

endpackage

// File: rtl/mem_wb_lane_reg.sv
// Single writeback lane register {we, addr, val, type} with load, hold and clear.
// Clear wins over load and restores the reset payload.
module mem_wb_lane_reg
   import mem_wb_pipe_pkg::*;
#(
   parameter int                 ADDR_W   = 5,
   parameter int                 DATA_W   = 32,
   parameter int                 TYPE_W   = 7,
   parameter logic [TYPE_W-1:0]  NOP_TYPE = TYPE_W'(ALOPI)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clear,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_val,
   input  logic [TYPE_W-1:0] d_type,
   output logic              q_we,
   output logic [ADDR_W-1:0] q_addr,
   output logic [DATA_W-1:0] q_val,
   output logic [TYPE_W-1:0] q_type
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_we   <= 1'b0;
         q_addr <= '0;
         q_val  <= DATA_W'(ZERO_WORD);
         q_type <= NOP_TYPE;
      end else if (clear) begin
         q_we   <= 1'b0;
         q_addr <= '0;
         q_val  <= DATA_W'(ZERO_WORD);
         q_type <= NOP_TYPE;
      end else if (load) begin
         q_we   <= d_we;
         q_addr <= d_addr;
         q_val  <= d_val;
         q_type <= d_type;
      end
   end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register, LANES wide, with a 2-entry skid buffer, flush and x0 suppression.
// state | meaning
// EMPTY | no beat held, out_valid=0
// ONE   | head entry holds a beat
// TWO   | head and skid hold beats, upstream blocked
module mem_wb_pipe
   import mem_wb_pipe_pkg::*;
#(
   parameter int                 LANES    = 1,
   parameter int                 ADDR_W   = 5,
   parameter int                 DATA_W   = 32,
   parameter int                 TYPE_W   = 7,
   parameter logic [TYPE_W-1:0]  NOP_TYPE = TYPE_W'(ALOPI)
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     rdy_in,
   input  logic                     flush_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES-1:0]         in_we,
   input  logic [LANES*ADDR_W-1:0]  in_rd_addr,
   input  logic [LANES*DATA_W-1:0]  in_rd_val,
   input  logic [LANES*TYPE_W-1:0]  in_ins_type,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES-1:0]         out_we,
   output logic [LANES*ADDR_W-1:0]  out_rd_addr,
   output logic [LANES*DATA_W-1:0]  out_rd_val,
   output logic [LANES*TYPE_W-1:0]  out_ins_type,
   output logic [1:0]               occupancy
);

   occ_t state;
   logic head_valid, skid_valid;
   logic acc, pop, move_ok;
   logic head_load, skid_load, head_from_skid;

   assign head_valid = (state != EMPTY);
   assign skid_valid = (state == TWO);

   assign in_ready  = rdy_in & ~skid_valid;
   assign acc       = in_valid & in_ready;
   assign pop       = head_valid & out_ready & rdy_in;
   assign out_valid = head_valid;
   assign occupancy = state;

   // Flush overrides everything, including a frozen pipe.
   assign move_ok        = rdy_in & ~flush_in;
   assign head_from_skid = (state == TWO);
   assign head_load      = move_ok & (((state == EMPTY) & acc) |
                                      ((state == ONE) & acc & pop) |
                                      ((state == TWO) & pop));
   assign skid_load      = move_ok & (state == ONE) & acc & ~pop;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= EMPTY;
      end else if (flush_in) begin
         state <= EMPTY;
      end else if (rdy_in) begin
         case (state)
            EMPTY: if (acc) state <= ONE;
            ONE: begin
               if (acc && !pop)      state <= TWO;
               else if (!acc && pop) state <= EMPTY;
            end
            TWO:     if (pop) state <= ONE;
            default: state <= EMPTY;
         endcase
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic              h_we, s_we;
      logic [ADDR_W-1:0] h_addr, s_addr;
      logic [DATA_W-1:0] h_val, s_val;
      logic [TYPE_W-1:0] h_type, s_type;

      mem_wb_lane_reg #(
         .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TYPE_W(TYPE_W), .NOP_TYPE(NOP_TYPE)
      ) u_head (
         .clk    (clk_in),
         .rst_n  (rst_n_in),
         .load   (head_load),
         .clear  (flush_in),
         .d_we   (head_from_skid ? s_we   : in_we[i]),
         .d_addr (head_from_skid ? s_addr : in_rd_addr[i*ADDR_W +: ADDR_W]),
         .d_val  (head_from_skid ? s_val  : in_rd_val[i*DATA_W +: DATA_W]),
         .d_type (head_from_skid ? s_type : in_ins_type[i*TYPE_W +: TYPE_W]),
         .q_we   (h_we),
         .q_addr (h_addr),
         .q_val  (h_val),
         .q_type (h_type)
      );

      mem_wb_lane_reg #(
         .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TYPE_W(TYPE_W), .NOP_TYPE(NOP_TYPE)
      ) u_skid (
         .clk    (clk_in),
         .rst_n  (rst_n_in),
         .load   (skid_load),
         .clear  (flush_in),
         .d_we   (in_we[i]),
         .d_addr (in_rd_addr[i*ADDR_W +: ADDR_W]),
         .d_val  (in_rd_val[i*DATA_W +: DATA_W]),
         .d_type (in_ins_type[i*TYPE_W +: TYPE_W]),
         .q_we   (s_we),
         .q_addr (s_addr),
         .q_val  (s_val),
         .q_type (s_type)
      );

      // x0 is hardwired zero, so a write to it must never reach the register file.
      assign out_we[i]                        = head_valid & h_we & (h_addr != '0);
      assign out_rd_addr[i*ADDR_W +: ADDR_W]  = h_addr;
      assign out_rd_val[i*DATA_W +: DATA_W]   = h_val;
      assign out_ins_type[i*TYPE_W +: TYPE_W] = h_type;
   end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed and scoreboarded checks of mem_wb_pipe with two lanes.
module tb_mem_wb_pipe;

   localparam int LANES = 2;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int TW    = 7;
   localparam int PW    = LANES * (1 + AW + DW + TW);
   localparam logic [LANES*TW-1:0] NOP2 = {7'h13, 7'h13};

   logic                  clk_in = 1'b0;
   logic                  rst_n_in;
   logic                  rdy_in;
   logic                  flush_in;
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES-1:0]      in_we;
   logic [LANES*AW-1:0]   in_rd_addr;
   logic [LANES*DW-1:0]   in_rd_val;
   logic [LANES*TW-1:0]   in_ins_type;
   logic                  out_valid;
   logic                  out_ready;
   logic [LANES-1:0]      out_we;
   logic [LANES*AW-1:0]   out_rd_addr;
   logic [LANES*DW-1:0]   out_rd_val;
   logic [LANES*TW-1:0]   out_ins_type;
   logic [1:0]            occupancy;

   int errors = 0;
   int checks = 0;

   mem_wb_pipe #(.LANES(LANES), .ADDR_W(AW), .DATA_W(DW), .TYPE_W(TW)) dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .rdy_in       (rdy_in),
      .flush_in     (flush_in),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_we        (in_we),
      .in_rd_addr   (in_rd_addr),
      .in_rd_val    (in_rd_val),
      .in_ins_type  (in_ins_type),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_we       (out_we),
      .out_rd_addr  (out_rd_addr),
      .out_rd_val   (out_rd_val),
      .out_ins_type (out_ins_type),
      .occupancy    (occupancy)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   function automatic logic [63:0] beat_val(input int k);
      return {32'hA000_0000 | 32'(k), 32'hB000_0000 | 32'(k)};
   endfunction

   task automatic set_beat(input int k);
      in_we       = 2'b11;
      in_rd_addr  = {5'(k + 1), 5'(k + 2)};
      in_rd_val   = beat_val(k);
      in_ins_type = {7'(k), 7'h33};
   endtask

   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] head_e;
   logic [LANES-1:0] w_exp;
   int sent, got, cyc;

   initial begin
      rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_we = '0; in_rd_addr = '0; in_rd_val = '0; in_ins_type = '0;
      tick(); tick();
      rst_n_in = 1'b1;

      // load a beat, then reset asynchronously between edges
      set_beat(1); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("pre_reset_occ", 64'(occupancy), 64'd1);
      #2 rst_n_in = 1'b0;
      #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_type", 64'(out_ins_type), 64'(NOP2));
      check("rst_we", 64'(out_we), 64'd0);
      check("rst_occ", 64'(occupancy), 64'd0);
      check("rst_addr", 64'(out_rd_addr), 64'd0);
      check("rst_val", out_rd_val, 64'd0);
      tick();
      rst_n_in = 1'b1;

      // single beat with lane 0 targeting x0
      out_ready = 1'b1; in_valid = 1'b1; in_we = 2'b11;
      in_rd_addr = {5'd3, 5'd0}; in_rd_val = {32'hDEAD_BEEF, 32'h1}; in_ins_type = {7'h03, 7'h03};
      tick();
      in_valid = 1'b0;
      check("single_valid", 64'(out_valid), 64'd1);
      check("single_we", 64'(out_we), 64'b10);
      check("single_val", out_rd_val, {32'hDEAD_BEEF, 32'h1});
      check("single_addr", 64'(out_rd_addr), 64'({5'd3, 5'd0}));
      tick();
      check("single_drain_valid", 64'(out_valid), 64'd0);
      check("single_drain_we", 64'(out_we), 64'd0);

      // backpressure: A, B held, C refused
      out_ready = 1'b0; in_valid = 1'b1; set_beat(2);
      tick();
      check("bp_occ1", 64'(occupancy), 64'd1);
      check("bp_ready1", 64'(in_ready), 64'd1);
      set_beat(3);
      tick();
      check("bp_occ2", 64'(occupancy), 64'd2);
      check("bp_ready0", 64'(in_ready), 64'd0);
      set_beat(4);
      tick();
      check("bp_occ_hold", 64'(occupancy), 64'd2);
      check("bp_head_a", out_rd_val, beat_val(2));
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("bp_head_b", out_rd_val, beat_val(3));
      check("bp_addr_b", 64'(out_rd_addr), 64'({5'd4, 5'd5}));
      check("bp_occ_b", 64'(occupancy), 64'd1);
      tick();
      check("bp_empty", 64'(out_valid), 64'd0);
      check("bp_occ0", 64'(occupancy), 64'd0);

      // stall with rdy_in low
      out_ready = 1'b0; in_valid = 1'b1; set_beat(10);
      tick();
      rdy_in = 1'b0; set_beat(11); out_ready = 1'b1;
      #1;
      check("stall_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_occ", 64'(occupancy), 64'd1);
         check("stall_val", out_rd_val, beat_val(10));
         check("stall_valid", 64'(out_valid), 64'd1);
      end
      rdy_in = 1'b1; in_valid = 1'b0;
      tick();
      check("stall_release", 64'(occupancy), 64'd0);

      // flush from full
      out_ready = 1'b0; in_valid = 1'b1; set_beat(20);
      tick();
      set_beat(21);
      tick();
      check("flush_pre_occ", 64'(occupancy), 64'd2);
      flush_in = 1'b1; set_beat(22);
      tick();
      flush_in = 1'b0; in_valid = 1'b0;
      check("flush_occ", 64'(occupancy), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_type", 64'(out_ins_type), 64'(NOP2));
      check("flush_we", 64'(out_we), 64'd0);
      check("flush_val", out_rd_val, 64'd0);

      // random streaming against a FIFO scoreboard
      sent = 0; got = 0; cyc = 0;
      while (got < 100 && cyc < 3000) begin
         rdy_in    = ($urandom_range(0, 7) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
         in_we     = LANES'($urandom_range(0, 3));
         in_rd_addr[AW-1:0]  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         in_rd_addr[2*AW-1:AW] = 5'($urandom_range(0, 31));
         in_rd_val   = {$urandom(), $urandom()};
         in_ins_type = {7'($urandom_range(0, 127)), 7'($urandom_range(0, 127))};
         #1;
         if (out_valid && out_ready && rdy_in) begin
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               head_e = exp_q.pop_front();
               check("sb_we", 64'(out_we), 64'(head_e[PW-1 -: LANES]));
               check("sb_addr", 64'(out_rd_addr), 64'(head_e[PW-LANES-1 -: LANES*AW]));
               check("sb_val", out_rd_val, head_e[LANES*TW +: LANES*DW]);
               check("sb_type", 64'(out_ins_type), 64'(head_e[LANES*TW-1:0]));
            end
            got++;
         end
         if (in_valid && in_ready) begin
            w_exp[0] = in_we[0] & (in_rd_addr[AW-1:0] != 0);
            w_exp[1] = in_we[1] & (in_rd_addr[2*AW-1:AW] != 0);
            exp_q.push_back({w_exp, in_rd_addr, in_rd_val, in_ins_type});
            sent++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      check("sb_sent", 64'(sent), 64'd100);
      check("sb_got", 64'(got), 64'd100);
      check("sb_leftover", 64'(exp_q.size()), 64'd0);
      check("sb_final_occ", 64'(occupancy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
